// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle for alu_issue_ctrl.
// Both channels use valid/ready semantics. A beat transfers on a rising clock
// edge where valid and ready are both high. A source that raises valid holds
// valid and its payload stable until that edge. A sink may change ready at any
// time.
// master: issue logic side. It drives requests and consumes responses.
// slave : alu_issue_ctrl side. It accepts requests and produces responses.
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_opcode;
  logic [5:0]       req_funct;
  logic [31:0]      req_rs;
  logic [31:0]      req_rt;
  logic [15:0]      req_imm;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_ovf_trap;
  logic             rsp_illegal;

  modport master (
    output req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_tag, rsp_ovf_trap, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm, req_tag,
    output req_ready,
    output rsp_valid, rsp_result, rsp_tag, rsp_ovf_trap, rsp_illegal,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side of the 32-bit ALU.
// It decodes MIPS R-type and I-type arithmetic/logic requests into a 3-bit ALU op.
// It registers the operands toward the combinational ALU and captures the result
// one cycle later. It then returns a tagged response.
// Optional macro ALU_OVF_TRAP_EN: when defined, add/sub/addi report signed
// overflow on rsp_ovf_trap. When undefined, rsp_ovf_trap is always 0.
// FSM: IDLE -> EXEC -> RESP for legal requests. IDLE -> RESP for illegal ones.
// The state is visible on o_dbg_state as IDLE=0, EXEC=1, RESP=2.
module alu_issue_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_alu_a;
  logic [31:0]      r_alu_b;
  logic [2:0]       r_alu_op;
  logic [31:0]      r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_valid;
  logic             r_rsp_ovf_trap;
  logic             r_rsp_illegal;

  logic             w_legal;
  logic [2:0]       w_op;
  logic [31:0]      w_b;
  logic             w_trap;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_ovf_trap;

`ifdef ALU_OVF_TRAP_EN
  logic             r_trap;
  assign w_ovf_trap = r_trap & alu_overflow;
`else
  logic             w_unused_ovf;
  assign w_unused_ovf = alu_overflow ^ w_trap;
  assign w_ovf_trap   = 1'b0;
`endif

  assign w_req_ready = (r_state == IDLE) & rst_n;
  assign w_accept    = bus.req_valid & w_req_ready;

  // Decode the opcode/funct pair into legality, the ALU op, operand b and the trapping class.
  always_comb begin
    w_legal = 1'b0;
    w_op    = OP_AND;
    w_b     = bus.req_rt;
    w_trap  = 1'b0;
    if (bus.req_opcode == 6'h00) begin
      case (bus.req_funct)
        6'h20: begin w_legal = 1'b1; w_op = OP_ADD; w_trap = 1'b1; end
        6'h21: begin w_legal = 1'b1; w_op = OP_ADD; end
        6'h22: begin w_legal = 1'b1; w_op = OP_SUB; w_trap = 1'b1; end
        6'h23: begin w_legal = 1'b1; w_op = OP_SUB; end
        6'h24: begin w_legal = 1'b1; w_op = OP_AND; end
        6'h25: begin w_legal = 1'b1; w_op = OP_OR;  end
        6'h2A: begin w_legal = 1'b1; w_op = OP_SLT; end
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (bus.req_opcode)
        6'h08: begin w_legal = 1'b1; w_op = OP_ADD; w_b = {{16{bus.req_imm[15]}}, bus.req_imm}; w_trap = 1'b1; end
        6'h09: begin w_legal = 1'b1; w_op = OP_ADD; w_b = {{16{bus.req_imm[15]}}, bus.req_imm}; end
        6'h0A: begin w_legal = 1'b1; w_op = OP_SLT; w_b = {{16{bus.req_imm[15]}}, bus.req_imm}; end
        6'h0C: begin w_legal = 1'b1; w_op = OP_AND; w_b = {16'h0000, bus.req_imm}; end
        6'h0D: begin w_legal = 1'b1; w_op = OP_OR;  w_b = {16'h0000, bus.req_imm}; end
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Next-state logic. RESP always has rsp_valid high, so rsp_ready alone completes the response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_legal ? EXEC : RESP;
      EXEC:    w_next_state = RESP;
      RESP:    if (bus.rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register. Reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Operand/response registers. The ALU operands change only when a legal request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_rsp_result   <= '0;
      r_rsp_tag      <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_ovf_trap <= 1'b0;
      r_rsp_illegal  <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      r_trap         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rsp_tag <= bus.req_tag;
            if (w_legal) begin
              r_alu_a  <= bus.req_rs;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
`ifdef ALU_OVF_TRAP_EN
              r_trap   <= w_trap;
`endif
            end else begin
              r_rsp_result   <= '0;
              r_rsp_illegal  <= 1'b1;
              r_rsp_ovf_trap <= 1'b0;
              r_rsp_valid    <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_rsp_result   <= alu_result;
          r_rsp_ovf_trap <= w_ovf_trap;
          r_rsp_illegal  <= 1'b0;
          r_rsp_valid    <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_tag      = r_rsp_tag;
  assign bus.rsp_ovf_trap = r_rsp_ovf_trap;
  assign bus.rsp_illegal  = r_rsp_illegal;
  assign alu_a            = r_alu_a;
  assign alu_b            = r_alu_b;
  assign alu_op           = r_alu_op;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. A behavioural ALU closes the loop. Expected
// responses are queued when a request is accepted and compared when the
// response handshake occurs.
module tb_alu_issue_ctrl;

  localparam bit TRAP_EN =
`ifdef ALU_OVF_TRAP_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic        legal;
    logic [2:0]  op;
    logic [31:0] b;
    logic        trap;
  } dec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;
  logic [37:0] exp_q[$];
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [2:0]  last_op;

  alu_issue_ctrl_if #(.TAG_W(4)) bus ();

  alu_issue_ctrl #(.TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = {31'd0, ($signed(a) < $signed(b))};
      3'd3: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd4: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  assign {alu_overflow, alu_result} = ref_alu(alu_op, alu_a, alu_b);

  function automatic dec_t ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                      input logic [31:0] rt, input logic [15:0] imm);
    dec_t d;
    d = '{legal: 1'b0, op: 3'd0, b: rt, trap: 1'b0};
    if (opc == 6'h00) begin
      if      (fn == 6'h20) d = '{1'b1, 3'd3, rt, 1'b1};
      else if (fn == 6'h21) d = '{1'b1, 3'd3, rt, 1'b0};
      else if (fn == 6'h22) d = '{1'b1, 3'd4, rt, 1'b1};
      else if (fn == 6'h23) d = '{1'b1, 3'd4, rt, 1'b0};
      else if (fn == 6'h24) d = '{1'b1, 3'd0, rt, 1'b0};
      else if (fn == 6'h25) d = '{1'b1, 3'd1, rt, 1'b0};
      else if (fn == 6'h2A) d = '{1'b1, 3'd2, rt, 1'b0};
    end else begin
      if      (opc == 6'h08) d = '{1'b1, 3'd3, {{16{imm[15]}}, imm}, 1'b1};
      else if (opc == 6'h09) d = '{1'b1, 3'd3, {{16{imm[15]}}, imm}, 1'b0};
      else if (opc == 6'h0A) d = '{1'b1, 3'd2, {{16{imm[15]}}, imm}, 1'b0};
      else if (opc == 6'h0C) d = '{1'b1, 3'd0, {16'h0000, imm}, 1'b0};
      else if (opc == 6'h0D) d = '{1'b1, 3'd1, {16'h0000, imm}, 1'b0};
    end
    return d;
  endfunction

  // Response word: {illegal, ovf_trap, tag, result}
  function automatic logic [37:0] mk(input logic ill, input logic trap, input logic [3:0] tag, input logic [31:0] res);
    return {ill, trap, tag, res};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input logic [3:0] tag);
    bus.req_opcode = opc;
    bus.req_funct  = fn;
    bus.req_rs     = rs;
    bus.req_rt     = rt;
    bus.req_imm    = imm;
    bus.req_tag    = tag;
    bus.req_valid  = 1'b1;
  endtask

  // Waits for acceptance of the driven request and queues its expected response.
  // Legal requests show rsp_valid on the second edge, counting the accept edge as the first.
  // Illegal requests show it on the accept edge itself.
  task automatic accept(input logic legal, input logic [2:0] e_op, input logic [31:0] e_b, input logic [37:0] e_rsp);
    int k;
    logic [31:0] rs;
    k  = 0;
    rs = bus.req_rs;
    while (!bus.req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_at_accept", 64'(bus.req_ready), 64'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_q.push_back(e_rsp);
    if (legal) begin
      last_a  = rs;
      last_b  = e_b;
      last_op = e_op;
      chk("alu_op", 64'(alu_op), 64'(e_op));
      chk("alu_a", 64'(alu_a), 64'(rs));
      chk("alu_b", 64'(alu_b), 64'(e_b));
      chk("rsp_valid_in_exec", 64'(bus.rsp_valid), 64'd0);
      @(posedge clk); #1;
      chk("rsp_valid_legal_latency", 64'(bus.rsp_valid), 64'd1);
    end else begin
      chk("rsp_valid_illegal_latency", 64'(bus.rsp_valid), 64'd1);
      chk("alu_op_unchanged", 64'(alu_op), 64'(last_op));
      chk("alu_a_unchanged", 64'(alu_a), 64'(last_a));
      chk("alu_b_unchanged", 64'(alu_b), 64'(last_b));
    end
  endtask

  // Holds rsp_ready low for 'stall' cycles, checking stability, then completes the response.
  task automatic collect(input int stall);
    logic [37:0] e;
    int k;
    k = 0;
    while (!bus.rsp_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() == 0) begin
      chk("exp_q_nonempty", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_rsp_payload", 64'({bus.rsp_illegal, bus.rsp_ovf_trap, bus.rsp_tag, bus.rsp_result}), 64'(exp_q[0]));
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    e = exp_q.pop_front();
    chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rsp_payload", 64'({bus.rsp_illegal, bus.rsp_ovf_trap, bus.rsp_tag, bus.rsp_result}), 64'(e));
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 64'(bus.rsp_valid), 64'd0);
    chk("req_ready_back_idle", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 64'({alu_op, bus.rsp_valid, bus.rsp_ovf_trap, bus.rsp_illegal, bus.rsp_tag, bus.req_ready, dbg_state}), 64'd0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
    chk({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    dec_t        d;
    logic [32:0] ar;
    logic [5:0]  opcs [12];
    logic [5:0]  fns  [12];
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    int          idx;

    opcs = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};
    fns  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    n_cmp = 0;
    n_fail = 0;
    last_a = '0;
    last_b = '0;
    last_op = '0;
    bus.req_valid = 1'b0;
    bus.req_opcode = '0;
    bus.req_funct = '0;
    bus.req_rs = '0;
    bus.req_rt = '0;
    bus.req_imm = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("req_ready_after_reset", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;

    // add 5+3
    set_req(6'h00, 6'h20, 32'h5, 32'h3, 16'h0, 4'd2);
    accept(1'b1, 3'd3, 32'h3, mk(1'b0, 1'b0, 4'd2, 32'h8));
    collect(0);
    // add overflow
    set_req(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 4'd3);
    accept(1'b1, 3'd3, 32'h1, mk(1'b0, TRAP_EN, 4'd3, 32'h80000000));
    collect(0);
    // addu never traps
    set_req(6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0, 4'd4);
    accept(1'b1, 3'd3, 32'h1, mk(1'b0, 1'b0, 4'd4, 32'h80000000));
    collect(1);
    // andi zero-extends
    set_req(6'h0C, 6'h00, 32'hFFFF1234, 32'hDEADBEEF, 16'h00FF, 4'd6);
    accept(1'b1, 3'd0, 32'h000000FF, mk(1'b0, 1'b0, 4'd6, 32'h00000034));
    collect(0);
    // slti sign-extends
    set_req(6'h0A, 6'h00, 32'hFFFFFFFE, 32'h0, 16'hFFFF, 4'd5);
    accept(1'b1, 3'd2, 32'hFFFFFFFF, mk(1'b0, 1'b0, 4'd5, 32'h1));
    collect(0);
    // mult is illegal; alu registers keep the slti values
    set_req(6'h00, 6'h18, 32'h11111111, 32'h22222222, 16'h0, 4'd7);
    accept(1'b0, 3'd0, 32'h0, mk(1'b1, 1'b0, 4'd7, 32'h0));
    collect(0);
    // lw opcode is illegal
    set_req(6'h23, 6'h20, 32'h1, 32'h1, 16'h1, 4'd8);
    accept(1'b0, 3'd0, 32'h0, mk(1'b1, 1'b0, 4'd8, 32'h0));
    collect(2);
    // sub overflow, then a 5-cycle stall with the next request already waiting
    set_req(6'h00, 6'h22, 32'h80000000, 32'h1, 16'h0, 4'd9);
    accept(1'b1, 3'd4, 32'h1, mk(1'b0, TRAP_EN, 4'd9, 32'h7FFFFFFF));
    set_req(6'h00, 6'h25, 32'h000000F0, 32'h0000000F, 16'h0, 4'd10);
    collect(5);
    accept(1'b1, 3'd1, 32'h0000000F, mk(1'b0, 1'b0, 4'd10, 32'h000000FF));
    collect(0);
    // ori zero-extends a high immediate bit
    set_req(6'h0D, 6'h00, 32'h1, 32'h0, 16'h8000, 4'd11);
    accept(1'b1, 3'd1, 32'h00008000, mk(1'b0, 1'b0, 4'd11, 32'h00008001));
    collect(0);
    // addi sign-extends a high immediate bit
    set_req(6'h08, 6'h00, 32'h00008000, 32'h0, 16'h8000, 4'd12);
    accept(1'b1, 3'd3, 32'hFFFF8000, mk(1'b0, 1'b0, 4'd12, 32'h0));
    collect(0);
    // addi overflow
    set_req(6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 16'h0001, 4'd13);
    accept(1'b1, 3'd3, 32'h1, mk(1'b0, TRAP_EN, 4'd13, 32'h80000000));
    collect(0);
    // subu wraps without trap
    set_req(6'h00, 6'h23, 32'h3, 32'h5, 16'h0, 4'd14);
    accept(1'b1, 3'd4, 32'h5, mk(1'b0, 1'b0, 4'd14, 32'hFFFFFFFE));
    collect(0);
    // slt signed compare
    set_req(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0, 4'd15);
    accept(1'b1, 3'd2, 32'h1, mk(1'b0, 1'b0, 4'd15, 32'h1));
    collect(0);

    // reset during EXEC aborts the request
    set_req(6'h00, 6'h20, 32'h10, 32'h20, 16'h0, 4'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("exec_state_before_abort", 64'(dbg_state), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_exec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_a = '0;
    last_b = '0;
    last_op = '0;
    #1;
    chk("req_ready_after_abort", 64'(bus.req_ready), 64'd1);
    chk("state_after_abort", 64'(dbg_state), 64'd0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    bus.rsp_ready = 1'b0;

    // random mix of legal and illegal requests
    for (int n = 0; n < 10; n++) begin
      idx = int'($urandom_range(0, 13));
      rs  = $urandom;
      rt  = $urandom;
      imm = 16'($urandom);
      if (idx < 12) begin
        set_req(opcs[idx], fns[idx], rs, rt, imm, 4'(n));
        d = ref_decode(opcs[idx], fns[idx], rt, imm);
      end else begin
        set_req(6'h00, 6'h1A, rs, rt, imm, 4'(n));
        d = ref_decode(6'h00, 6'h1A, rt, imm);
      end
      ar = ref_alu(d.op, rs, d.b);
      if (d.legal)
        accept(1'b1, d.op, d.b, mk(1'b0, d.trap & ar[32] & TRAP_EN, 4'(n), ar[31:0]));
      else
        accept(1'b0, 3'd0, 32'h0, mk(1'b1, 1'b0, 4'(n), 32'h0));
      collect(int'($urandom_range(0, 2)));
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
